// File: rtl/fifo_arb_pkg.sv
// ----------------------------------------------------------------------------
// fifo_arb_pkg
//   Shared types and helpers for the FIFO write-port arbiter.
//   - arb_state_t : arbiter FSM states
//   - clog2       : ceiling log2, usable in constant expressions
//   - NREQ_MAX    : largest requester count the arbiter is meant to serve
// ----------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_t;

    localparam int unsigned NREQ_MAX = 16;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// ----------------------------------------------------------------------------
// fifo_wr_arbiter_if
//   Bundles the requester side and FIFO write side of the arbiter.
//   Requester/FIFO side (master drives): req, last, din, wfull
//   Arbiter side        (slave drives) : gnt, gnt_id, busy, winc, wdata
// ----------------------------------------------------------------------------
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned DSIZE = 8
);

    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        last;
    logic [NREQ*DSIZE-1:0]  din;
    logic                   wfull;
    logic [NREQ-1:0]        gnt;
    logic [clog2(NREQ)-1:0] gnt_id;
    logic                   busy;
    logic                   winc;
    logic [DSIZE-1:0]       wdata;

    modport master (
        output req, last, din, wfull,
        input  gnt, gnt_id, busy, winc, wdata
    );

    modport slave (
        input  req, last, din, wfull,
        output gnt, gnt_id, busy, winc, wdata
    );

endinterface

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//   Combinational rotating-priority encoder. Returns the first set bit of
//   i_req found searching upward from i_ptr with wrap-around.
//   i_req   : request vector
//   i_ptr   : index with highest priority
//   o_valid : any request present
//   o_idx   : chosen index (0 when none)
// ----------------------------------------------------------------------------
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned W = clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic         o_valid,
    output logic [W-1:0] o_idx
);

    logic [W-1:0] w_cand;

    // Scan offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        w_cand  = '0;
        for (int unsigned k = N; k > 0; k--) begin
            w_cand = W'((32'(i_ptr) + k - 1) % N);
            if (i_req[w_cand]) begin
                o_idx = w_cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Shares the FIFO write port among NREQ requesters with round-robin,
//   burst-based grants. The owner keeps the port until it marks last, drops
//   req, or reaches MAXBURST accepted beats; it stalls while wfull is high.
//   wclk : write-domain clock
//   wrst : asynchronous active-high reset
//   bus  : slave side of fifo_wr_arbiter_if
//          in : req, last, din, wfull
//          out: gnt (one-hot, registered), gnt_id, busy, winc, wdata
// ----------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned DSIZE    = 8,
    parameter int unsigned MAXBURST = 4
) (
    input  logic              wclk,
    input  logic              wrst,
    fifo_wr_arbiter_if.slave  bus
);

    localparam int unsigned IDW = clog2(NREQ);
    localparam int unsigned CW  = clog2(MAXBURST) + 1;

    arb_state_t       r_state;
    logic [NREQ-1:0]  r_gnt;
    logic [IDW-1:0]   r_gnt_id;
    logic [IDW-1:0]   r_rr_ptr;
    logic [CW-1:0]    r_beat_cnt;

    arb_state_t       w_nxt_state;
    logic [NREQ-1:0]  w_nxt_gnt;
    logic [IDW-1:0]   w_nxt_gnt_id;
    logic [IDW-1:0]   w_nxt_rr_ptr;
    logic [CW-1:0]    w_nxt_beat_cnt;

    logic             w_pick_valid;
    logic [IDW-1:0]   w_pick_idx;
    logic             w_busy;
    logic             w_owner_req;
    logic             w_owner_last;
    logic             w_accept;
    logic             w_release;
    logic [DSIZE-1:0] w_din [NREQ];

    rr_pick #(
        .N (NREQ),
        .W (IDW)
    ) u_rr_pick (
        .i_req   (bus.req),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_din
        assign w_din[gi] = bus.din[gi*DSIZE +: DSIZE];
    end

    assign w_busy       = (r_state == ARB_BURST);
    assign w_owner_req  = bus.req[r_gnt_id];
    assign w_owner_last = bus.last[r_gnt_id];
    assign w_accept     = w_busy & w_owner_req & ~bus.wfull;
    // A dropped request releases even while wfull holds the beat back.
    assign w_release    = w_busy & (~w_owner_req |
                          (w_accept & (w_owner_last | (r_beat_cnt == CW'(MAXBURST - 1)))));

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_state    <= ARB_IDLE;
            r_gnt      <= '0;
            r_gnt_id   <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_nxt_state;
            r_gnt      <= w_nxt_gnt;
            r_gnt_id   <= w_nxt_gnt_id;
            r_rr_ptr   <= w_nxt_rr_ptr;
            r_beat_cnt <= w_nxt_beat_cnt;
        end
    end

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_gnt      = r_gnt;
        w_nxt_gnt_id   = r_gnt_id;
        w_nxt_rr_ptr   = r_rr_ptr;
        w_nxt_beat_cnt = r_beat_cnt;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    w_nxt_state    = ARB_BURST;
                    w_nxt_gnt      = NREQ'(1) << w_pick_idx;
                    w_nxt_gnt_id   = w_pick_idx;
                    w_nxt_beat_cnt = '0;
                end
            end
            ARB_BURST: begin
                if (w_release) begin
                    w_nxt_state    = ARB_IDLE;
                    w_nxt_gnt      = '0;
                    w_nxt_gnt_id   = '0;
                    w_nxt_beat_cnt = '0;
                    w_nxt_rr_ptr   = (r_gnt_id == IDW'(NREQ - 1)) ? '0 : r_gnt_id + 1'b1;
                end else if (w_accept) begin
                    w_nxt_beat_cnt = r_beat_cnt + 1'b1;
                end
            end
            default: begin
                w_nxt_state = ARB_IDLE;
            end
        endcase
    end

    assign bus.gnt    = r_gnt;
    assign bus.gnt_id = r_gnt_id;
    assign bus.busy   = w_busy;
    assign bus.winc   = w_accept;
    assign bus.wdata  = w_busy ? w_din[r_gnt_id] : '0;

endmodule
